// File: rtl/hazard3_hart_reset_ctrl_pkg.sv
// Shared definitions for the Hazard3 per-hart reset sequencer:
// the hart FSM state encoding and the counter sizing helper.
package hazard3_hart_reset_ctrl_pkg;

   localparam int MAX_HARTS = 32;

   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_HOLD    = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;

   // One counter serves both the hold and the stagger phase, so it must
   // cover the longer of the two terminal counts.
   function automatic int cnt_width(input int reset_cycles, input int max_release);
      int longest;
      int width;
      longest = (reset_cycles > max_release) ? reset_cycles : max_release;
      width   = $clog2(longest + 1);
      return (width < 1) ? 1 : width;
   endfunction

endpackage

// File: rtl/hazard3_hart_reset_ctrl_if.sv
// Request/status bundle between the debug module and the hart reset
// sequencer. The master raises requests, the slave drives the CPU resets.
interface hazard3_hart_reset_ctrl_if #(
   parameter int N_HARTS = 2
);

   logic               sys_reset_req;
   logic [N_HARTS-1:0] hart_reset_req;
   logic [N_HARTS-1:0] hart_rst_n;
   logic [N_HARTS-1:0] hart_reset_done;
   logic               sys_reset_done;

   modport master (
      output sys_reset_req,
      output hart_reset_req,
      input  hart_rst_n,
      input  hart_reset_done,
      input  sys_reset_done
   );

   modport slave (
      input  sys_reset_req,
      input  hart_reset_req,
      output hart_rst_n,
      output hart_reset_done,
      output sys_reset_done
   );

endinterface

// File: rtl/hazard3_hart_reset_fsm.sv
// Reset sequencer for a single hart: holds reset for a minimum length,
// then waits out this hart's stagger delay before letting the CPU run.
module hazard3_hart_reset_fsm
   import hazard3_hart_reset_ctrl_pkg::*;
#(
   parameter int RESET_CYCLES   = 4,
   parameter int RELEASE_CYCLES = 0,
   parameter int CNT_W          = cnt_width(RESET_CYCLES, RELEASE_CYCLES)
) (
   input  logic clk,
   input  logic rst,
   input  logic req,
   output logic rst_n,
   output logic done
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] REL_LAST  =
      CNT_W'((RELEASE_CYCLES > 0) ? RELEASE_CYCLES - 1 : 0);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   // The hold count saturates rather than restarting, so a long request
   // simply extends the hold until it drops.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_RUN: begin
            if (req) begin
               state_nxt = ST_HOLD;
               cnt_nxt   = '0;
            end
         end
         ST_HOLD: begin
            if (cnt != HOLD_LAST) begin
               cnt_nxt = cnt + 1'b1;
            end
            if (!req && cnt == HOLD_LAST) begin
               if (RELEASE_CYCLES > 0) begin
                  state_nxt = ST_RELEASE;
                  cnt_nxt   = '0;
               end else begin
                  state_nxt = ST_RUN;
               end
            end
         end
         ST_RELEASE: begin
            // A new request outranks the release that would happen this cycle.
            if (req) begin
               state_nxt = ST_HOLD;
               cnt_nxt   = '0;
            end else if (cnt == REL_LAST) begin
               state_nxt = ST_RUN;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = ST_HOLD;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_HOLD;
         cnt   <= '0;
         rst_n <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         rst_n <= (state_nxt == ST_RUN);
      end
   end

   // The request term is deliberately combinational so done never lags a new request.
   assign done = (state == ST_RUN) & ~req;

endmodule

// File: rtl/hazard3_hart_reset_ctrl.sv
// N-hart reset sequencer: merges the system and per-hart requests and
// runs one staggered reset FSM per hart.
module hazard3_hart_reset_ctrl
   import hazard3_hart_reset_ctrl_pkg::*;
#(
   parameter int N_HARTS        = 2,
   parameter int RESET_CYCLES   = 4,
   parameter int STAGGER_CYCLES = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   hazard3_hart_reset_ctrl_if.slave  bus
);

   localparam int CNT_W = cnt_width(RESET_CYCLES, STAGGER_CYCLES * (N_HARTS - 1));

   if (N_HARTS < 1 || N_HARTS > MAX_HARTS) begin : g_bad_n_harts
      $error("hazard3_hart_reset_ctrl: N_HARTS must be in 1..32");
   end
   if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
      $error("hazard3_hart_reset_ctrl: RESET_CYCLES must be at least 1");
   end
   if (STAGGER_CYCLES < 0) begin : g_bad_stagger
      $error("hazard3_hart_reset_ctrl: STAGGER_CYCLES must not be negative");
   end

   logic [N_HARTS-1:0] req;
   logic [N_HARTS-1:0] rst_n_vec;
   logic [N_HARTS-1:0] done_vec;

   assign req = {N_HARTS{bus.sys_reset_req}} | bus.hart_reset_req;

   for (genvar i = 0; i < N_HARTS; i++) begin : g_hart
      hazard3_hart_reset_fsm #(
         .RESET_CYCLES   (RESET_CYCLES),
         .RELEASE_CYCLES (STAGGER_CYCLES * i),
         .CNT_W          (CNT_W)
      ) u_fsm (
         .clk   (clk),
         .rst   (rst),
         .req   (req[i]),
         .rst_n (rst_n_vec[i]),
         .done  (done_vec[i])
      );
   end

   assign bus.hart_rst_n      = rst_n_vec;
   assign bus.hart_reset_done = done_vec;
   assign bus.sys_reset_done  = (&done_vec) & ~bus.sys_reset_req;

endmodule
